s2p_rr_scheduler: RTL and testbench
===================================

Name: s2p_rr_scheduler

Overview:
- Round-robin scheduler that shares one serial-to-parallel byte converter among NREQ serial requesters.
- Sequences each 8-bit conversion: drives the converter's start strobe and serial bit, waits for the end-of-conversion flag, then returns the byte tagged with the requester ID.
- Sits between the serial front-end sources and the byte consumer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ.
- TMO_CYC, 4, watchdog limit in cycles waiting for s2p_done (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester conversion request; level; held until grant seen.
- ser_d  in  NREQ  per-requester serial bit, LSB first, one bit per granted cycle.
- grant  out  NREQ  one-hot grant; high for exactly 8 cycles per transfer.
- s2p_start  out  1  converter start strobe; high in first grant cycle only.
- s2p_d  out  1  converter serial input = ser_d[granted index]; 0 when no grant.
- s2p_done  in  1  converter end-of-conversion pulse.
- s2p_data  in  8  converter parallel byte; valid while s2p_done=1.
- out_valid  out  1  one-cycle pulse: out_data/out_id valid.
- out_data  out  8  captured byte.
- out_id  out  IDW  index of requester that produced out_data.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky timeout flag (optional feature; tied 0 without it).

Behaviour:
- Reset values: grant=0, s2p_start=0, out_valid=0, out_data=0, out_id=0, busy=0, err=0, state=IDLE, bit counter=0, rr pointer=NREQ-1, so requester 0 has highest priority first.
- States and transitions:
  - IDLE: if any req bit is set, register the chosen index and go to SHIFT; grant rises the next cycle.
  - SHIFT: 8 cycles (bit counter 0..7).
    - grant[idx]=1 throughout; s2p_start=1 when counter=0.
    - s2p_d is combinational from ser_d[idx].
    - After counter=7, go to WAIT.
  - WAIT: grant=0. When s2p_done=1, capture s2p_data into out_data, capture idx into out_id, set rr pointer=idx, and go to IDLE. out_valid is registered and pulses in the following cycle.
- Arbitration: search starts at (rr pointer+1) mod NREQ, ascending with wrap; first set req wins. Indices >= NREQ are never granted.
- Timing for the request at T0 (IDLE):
  - grant and s2p_start at T1; bits at T1..T8.
  - s2p_done is expected at T9; out_valid at T10.
  - Next grant at T11 at the earliest, giving a throughput of 1 byte per 10 cycles.
- Boundary conditions:
  - req deasserted mid-SHIFT is ignored; the transfer completes and the byte is delivered.
  - s2p_done while not in WAIT is ignored.
  - s2p_done and a new req in the same cycle: the done is handled first; the new req is arbitrated in IDLE next cycle.
  - Only one requester's request bit asserted: that requester is granted repeatedly; no starvation of others.
  - rst_n low mid-transfer: grant and s2p_start drop immediately (async); no out_valid for the aborted byte.

Optional Feature:
- Macro: S2P_SCHED_TIMEOUT_EN.
- With the macro defined:
  - In WAIT, count cycles. If TMO_CYC cycles pass without s2p_done, set err=1 (sticky until reset) and return to IDLE without out_valid.
  - rr pointer still advances past the timed-out requester.
- Without the macro: WAIT holds indefinitely; err is constant 0; no counter logic is synthesised.

Test Plan:
- Single request:
  - Stimulus: reset release; req=4'b0001; ser_d[0] drives 0xA5 LSB first (1,0,1,0,0,1,0,1) with a behavioural converter model.
  - Response: grant=0001 for 8 cycles, s2p_start in first cycle only, out_valid 10 cycles after req, out_data=0xA5, out_id=0.
- Round robin: req=4'b1111 held. Grant order must be 0,1,2,3,0; each byte is tagged with the matching out_id; per-requester bytes 0x11,0x22,0x33,0x44 are returned correctly.
- Request withdrawal: req[2] drops at the 3rd SHIFT cycle; the transfer still completes with the full byte and out_id=2; requester 2 is not regranted.
- Reset mid-SHIFT: rst_n pulsed low at the 5th bit. Response: grant=0 and busy=0 at once, no out_valid; after release with req=4'b0010, requester 1 is granted with a clean 8-bit transfer.
- Timeout with S2P_SCHED_TIMEOUT_EN and TMO_CYC=4: the model suppresses s2p_done. Response: err=1 four cycles into WAIT, no out_valid, return to IDLE; the next request is served normally and err stays 1.

Source files
------------

// File: rtl/s2p_rr_scheduler.sv
// s2p_rr_scheduler: round-robin scheduler sharing one serial-to-parallel byte
// converter among NREQ serial requesters. Each granted transfer shifts 8 bits
// (LSB first) into the converter, waits for s2p_done and returns the byte
// tagged with the requester ID.
// Optional feature macro: S2P_SCHED_TIMEOUT_EN -- adds a TMO_CYC-cycle watchdog
// in WAIT and a sticky err flag; without it err is tied 0.
module s2p_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TMO_CYC = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] ser_d,
    output logic [NREQ-1:0] grant,
    output logic            s2p_start,
    output logic            s2p_d,
    input  logic            s2p_done,
    input  logic [7:0]      s2p_data,
    output logic            out_valid,
    output logic [7:0]      out_data,
    output logic [IDW-1:0]  out_id,
    output logic            busy,
    output logic            err
);

    // Reject configurations the arbiter index arithmetic cannot represent.
    if (NREQ < 2 || NREQ > 8 || (2 ** IDW) < NREQ || TMO_CYC < 1) begin : g_cfg_check
        $error("s2p_rr_scheduler: invalid NREQ/IDW/TMO_CYC combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT
    } state_t;

    localparam int CW = IDW + 1;

    state_t         state;
    logic [IDW-1:0] idx;
    logic [2:0]     bit_cnt;
    logic [IDW-1:0] rr_ptr;

    logic           arb_hit;
    logic [IDW-1:0] arb_idx;
    logic [CW-1:0]  cand;

`ifdef S2P_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    // Serial bit to the converter: the granted requester's line, 0 when idle.
    assign s2p_d = |(grant & ser_d);

    // Round-robin search starting just after the last served requester.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + CW'(i + 32'd1);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!arb_hit && req[cand[IDW-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = cand[IDW-1:0];
            end
        end
    end

    // Transfer sequencer with registered grant/strobe/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            bit_cnt   <= '0;
            rr_ptr    <= IDW'(NREQ - 1);
            grant     <= '0;
            s2p_start <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            busy      <= 1'b0;
`ifdef S2P_SCHED_TIMEOUT_EN
            err       <= 1'b0;
            tmo_cnt   <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_hit) begin
                        idx       <= arb_idx;
                        grant     <= {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
                        s2p_start <= 1'b1;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    s2p_start <= 1'b0;
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        grant <= '0;
                        state <= WAIT;
`ifdef S2P_SCHED_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (s2p_done) begin
                        out_data  <= s2p_data;
                        out_id    <= idx;
                        out_valid <= 1'b1;
                        rr_ptr    <= idx;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef S2P_SCHED_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TMO_CYC - 1)) begin
                        // Abandon the byte but still rotate past this requester.
                        err    <= 1'b1;
                        rr_ptr <= idx;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef S2P_SCHED_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_s2p_rr_scheduler.sv
// tb_s2p_rr_scheduler: directed self-checking bench for s2p_rr_scheduler with
// behavioural serial sources and a behavioural converter model.
module tb_s2p_rr_scheduler;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TMO_CYC = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] ser_d;
    logic [NREQ-1:0] grant;
    logic            s2p_start;
    logic            s2p_d;
    logic            s2p_done;
    logic [7:0]      s2p_data;
    logic            out_valid;
    logic [7:0]      out_data;
    logic [IDW-1:0]  out_id;
    logic            busy;
    logic            err;

    int checks = 0;
    int errors = 0;

    // Source model: each requester presents its byte LSB first while granted.
    logic [7:0] tx_byte [NREQ];
    logic [2:0] tx_cnt  [NREQ];

    // Converter model state and fault injection controls.
    logic [7:0] cv_sr;
    logic [2:0] cv_cnt;
    logic       cv_act;
    logic       cv_done;
    logic [7:0] cv_data;
    logic       suppress_done = 1'b0;
    logic       inj_done = 1'b0;
    logic [7:0] inj_data = 8'h00;

    always #5 clk = ~clk;

    // Advance per-requester bit pointer while that requester is granted.
    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            tx_cnt[i] <= grant[i] ? tx_cnt[i] + 3'd1 : 3'd0;
        end
    end

    // Serial line of each requester.
    always_comb begin
        for (int j = 0; j < NREQ; j++) begin
            ser_d[j] = tx_byte[j][tx_cnt[j]];
        end
    end

    // Converter: shift 8 bits after start, pulse done with the byte next cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_sr   <= '0;
            cv_cnt  <= '0;
            cv_act  <= 1'b0;
            cv_done <= 1'b0;
            cv_data <= '0;
        end else begin
            cv_done <= 1'b0;
            if (s2p_start) begin
                cv_act <= 1'b1;
                cv_cnt <= 3'd1;
                cv_sr  <= {s2p_d, 7'b0};
            end else if (cv_act) begin
                cv_sr  <= {s2p_d, cv_sr[7:1]};
                cv_cnt <= cv_cnt + 3'd1;
                if (cv_cnt == 3'd7) begin
                    cv_act  <= 1'b0;
                    cv_done <= !suppress_done;
                    cv_data <= {s2p_d, cv_sr[7:1]};
                end
            end
        end
    end

    assign s2p_done = cv_done | inj_done;
    assign s2p_data = inj_done ? inj_data : cv_data;

    s2p_rr_scheduler #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ser_d     (ser_d),
        .grant     (grant),
        .s2p_start (s2p_start),
        .s2p_d     (s2p_d),
        .s2p_done  (s2p_done),
        .s2p_data  (s2p_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy),
        .err       (err)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        inj_done = 1'b0;
        suppress_done = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++; $display("FAIL reset_grant got %b exp 0000", grant);
        end
        checks++;
        if ({s2p_start, s2p_d, out_valid, busy, err} !== 5'b00000) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {s2p_start, s2p_d, out_valid, busy, err});
        end
        checks++;
        if (out_data !== 8'h00 || out_id !== 2'd0) begin
            errors++; $display("FAIL reset_out got data %h id %0d exp data 00 id 0", out_data, out_id);
        end
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({grant, s2p_start, out_valid, busy} !== 7'b0) begin
            errors++; $display("FAIL reset_idle got %b exp 0", {grant, s2p_start, out_valid, busy});
        end
    endtask

    task automatic test_single();
        logic [7:0] b;
        logic       exp_d;
        b = 8'hA5;
        do_reset();
        tx_byte[0] = 8'hA5;
        req = 4'b0001;
        for (int n = 1; n <= 11; n++) begin
            step();
            exp_d = (n <= 8) ? b[n-1] : 1'b0;
            checks++;
            if (grant !== ((n <= 8) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL single_grant cyc %0d got %b", n, grant);
            end
            checks++;
            if ({s2p_start, s2p_d, out_valid, busy} !== {n == 1, exp_d, n == 10, n <= 9}) begin
                errors++; $display("FAIL single_flags cyc %0d got %b exp %b", n,
                    {s2p_start, s2p_d, out_valid, busy}, {n == 1, exp_d, n == 10, n <= 9});
            end
            if (n == 10) begin
                checks++;
                if (out_data !== 8'hA5 || out_id !== 2'd0) begin
                    errors++; $display("FAIL single_out got data %h id %0d exp data a5 id 0", out_data, out_id);
                end
            end
            if (n == 1) req = 4'b0000;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gnt [5];
        logic [1:0] ids [5];
        logic [7:0] dat [5];
        int         cyc [5];
        logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] exp_dat [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        int nstart = 0;
        int nval = 0;
        do_reset();
        tx_byte[0] = 8'h11; tx_byte[1] = 8'h22; tx_byte[2] = 8'h33; tx_byte[3] = 8'h44;
        req = 4'b1111;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (s2p_start) begin
                if (nstart < 5) gnt[nstart] = grant;
                nstart++;
                if (nstart == 5) req = 4'b0000;
            end
            if (out_valid) begin
                if (nval < 5) begin
                    ids[nval] = out_id; dat[nval] = out_data; cyc[nval] = n;
                end
                nval++;
            end
        end
        checks++;
        if (nstart != 5 || nval != 5) begin
            errors++; $display("FAIL rr_count got starts %0d valids %0d exp 5 5", nstart, nval);
        end
        for (int k = 0; k < 5; k++) begin
            if (k < nstart && k < nval) begin
                checks++;
                if (gnt[k] !== exp_gnt[k]) begin
                    errors++; $display("FAIL rr_grant #%0d got %b exp %b", k, gnt[k], exp_gnt[k]);
                end
                checks++;
                if (ids[k] !== exp_id[k] || dat[k] !== exp_dat[k]) begin
                    errors++; $display("FAIL rr_out #%0d got id %0d data %h exp id %0d data %h",
                        k, ids[k], dat[k], exp_id[k], exp_dat[k]);
                end
                checks++;
                if (cyc[k] != 10 + 10 * k) begin
                    errors++; $display("FAIL rr_timing #%0d got cyc %0d exp %0d", k, cyc[k], 10 + 10 * k);
                end
            end
        end
    endtask

    task automatic test_withdraw();
        logic [3:0] gnt [4];
        logic [1:0] ids [4];
        logic [7:0] dat [4];
        int nstart = 0;
        int nval = 0;
        do_reset();
        tx_byte[2] = 8'h33; tx_byte[3] = 8'h44;
        req = 4'b1100;
        for (int n = 1; n <= 35; n++) begin
            step();
            if (s2p_start) begin
                if (nstart < 4) gnt[nstart] = grant;
                nstart++;
            end
            if (out_valid) begin
                if (nval < 4) begin ids[nval] = out_id; dat[nval] = out_data; end
                nval++;
            end
            if (n == 3) req = 4'b1000;
            if (n == 11) req = 4'b0000;
        end
        checks++;
        if (nstart != 2 || nval != 2) begin
            errors++; $display("FAIL wd_count got starts %0d valids %0d exp 2 2", nstart, nval);
        end else begin
            checks++;
            if (gnt[0] !== 4'b0100 || gnt[1] !== 4'b1000) begin
                errors++; $display("FAIL wd_grant got %b %b exp 0100 1000", gnt[0], gnt[1]);
            end
            checks++;
            if (ids[0] !== 2'd2 || dat[0] !== 8'h33) begin
                errors++; $display("FAIL wd_out got id %0d data %h exp id 2 data 33", ids[0], dat[0]);
            end
            checks++;
            if (ids[1] !== 2'd3 || dat[1] !== 8'h44) begin
                errors++; $display("FAIL wd_next got id %0d data %h exp id 3 data 44", ids[1], dat[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nval = 0;
        int vcyc = 0;
        do_reset();
        tx_byte[0] = 8'hFF; tx_byte[1] = 8'h5C;
        req = 4'b0001;
        for (int n = 1; n <= 5; n++) begin
            step();
            if (n == 1) req = 4'b0000;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, s2p_start, busy, out_valid} !== 7'b0) begin
            errors++; $display("FAIL rstmid_drop got %b exp 0", {grant, s2p_start, busy, out_valid});
        end
        step();
        step();
        rst_n = 1'b1;
        req = 4'b0010;
        for (int n = 1; n <= 14; n++) begin
            step();
            if (n == 1) begin
                checks++;
                if (grant !== 4'b0010 || s2p_start !== 1'b1) begin
                    errors++; $display("FAIL rstmid_grant got %b start %b exp 0010 1", grant, s2p_start);
                end
                req = 4'b0000;
            end
            if (out_valid) begin
                nval++;
                vcyc = n;
                checks++;
                if (out_id !== 2'd1 || out_data !== 8'h5C) begin
                    errors++; $display("FAIL rstmid_out got id %0d data %h exp id 1 data 5c", out_id, out_data);
                end
            end
        end
        checks++;
        if (nval != 1 || vcyc != 10) begin
            errors++; $display("FAIL rstmid_valid got count %0d cyc %0d exp 1 10", nval, vcyc);
        end
    endtask

    task automatic test_done_outside_wait();
        int nval = 0;
        do_reset();
        tx_byte[2] = 8'h96;
        inj_done = 1'b1; inj_data = 8'hEE;
        step();
        inj_done = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL idle_done got valid %b busy %b data %h exp 0 0 00", out_valid, busy, out_data);
        end
        req = 4'b0100;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 1) req = 4'b0000;
            if (n == 4) begin inj_done = 1'b1; inj_data = 8'h3C; end
            if (n == 5) inj_done = 1'b0;
            if (out_valid) begin
                nval++;
                checks++;
                if (n != 10 || out_data !== 8'h96 || out_id !== 2'd2) begin
                    errors++; $display("FAIL shift_done got cyc %0d data %h id %0d exp cyc 10 data 96 id 2",
                        n, out_data, out_id);
                end
            end
        end
        checks++;
        if (nval != 1) begin
            errors++; $display("FAIL shift_done_count got %0d exp 1", nval);
        end
    endtask

    task automatic test_back_to_back();
        int nval = 0;
        do_reset();
        tx_byte[0] = 8'hC3; tx_byte[3] = 8'h0F;
        req = 4'b0001;
        for (int n = 1; n <= 22; n++) begin
            step();
            if (n == 10) begin
                checks++;
                if (grant !== 4'b0000 || out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 8'hC3) begin
                    errors++; $display("FAIL b2b_first got grant %b valid %b id %0d data %h exp 0000 1 0 c3",
                        grant, out_valid, out_id, out_data);
                end
            end
            if (n == 11) begin
                checks++;
                if (grant !== 4'b1000 || s2p_start !== 1'b1) begin
                    errors++; $display("FAIL b2b_regrant got %b start %b exp 1000 1", grant, s2p_start);
                end
            end
            if (out_valid) nval++;
            if (n == 20) begin
                checks++;
                if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 8'h0F) begin
                    errors++; $display("FAIL b2b_second got valid %b id %0d data %h exp 1 3 0f", out_valid, out_id, out_data);
                end
            end
            if (n == 1) req = 4'b0000;
            if (n == 9) req = 4'b1000;
            if (n == 12) req = 4'b0000;
        end
        checks++;
        if (nval != 2) begin
            errors++; $display("FAIL b2b_count got %0d exp 2", nval);
        end
    endtask

    task automatic test_single_requester();
        logic [3:0] gnt [5];
        logic [3:0] exp_gnt [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
        int nstart = 0;
        do_reset();
        tx_byte[0] = 8'h11; tx_byte[1] = 8'h22;
        req = 4'b0010;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (s2p_start) begin
                if (nstart < 5) gnt[nstart] = grant;
                nstart++;
            end
            if (n == 25) req = 4'b0011;
            if (n == 31) req = 4'b0000;
        end
        checks++;
        if (nstart != 4) begin
            errors++; $display("FAIL solo_count got %0d exp 4", nstart);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (gnt[k] !== exp_gnt[k]) begin
                    errors++; $display("FAIL solo_grant #%0d got %b exp %b", k, gnt[k], exp_gnt[k]);
                end
            end
        end
    endtask

`ifdef S2P_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int nval = 0;
        do_reset();
        tx_byte[0] = 8'h11; tx_byte[1] = 8'h22;
        suppress_done = 1'b1;
        req = 4'b0001;
        for (int n = 1; n <= 13; n++) begin
            step();
            if (n == 1) req = 4'b0000;
            if (out_valid) nval++;
            if (n == 12) begin
                checks++;
                if (err !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL tmo_early got err %b busy %b exp 0 1", err, busy);
                end
            end
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || nval != 0) begin
            errors++; $display("FAIL tmo_fire got err %b busy %b valids %0d exp 1 0 0", err, busy, nval);
        end
        suppress_done = 1'b0;
        req = 4'b0010;
        for (int n = 1; n <= 11; n++) begin
            step();
            if (n == 1) req = 4'b0000;
            if (n == 10) begin
                checks++;
                if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 8'h22 || err !== 1'b1) begin
                    errors++; $display("FAIL tmo_next got valid %b id %0d data %h err %b exp 1 1 22 1",
                        out_valid, out_id, out_data, err);
                end
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NREQ; i++) tx_byte[i] = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_reset_mid();
        test_done_outside_wait();
        test_back_to_back();
        test_single_requester();
`ifdef S2P_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
